// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode values,
// FSM state encoding and the default operand width used by the datapath.
package mult_div_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control unit / datapath and mult_div.
// The master side issues operations; the slave side is the arithmetic unit.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mult_div_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep the
// difference when it does not borrow. A single (WIDTH+1)-bit subtractor.
module mult_div_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; the top bit of diff is the borrow.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply/divide producing the HI/LO pair.
// MULT: radix-2 Booth, one step per cycle on a 2*WIDTH+1 accumulator.
// DIV : restoring division on magnitudes, signs fixed up when entering FIN.
// The accumulator is shared: {upper, lower, q_-1} for Booth, {rem, quo, 0}
// for division. hi/lo/div_zero only change on the edge that enters FIN.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH:0]   acc_reg;
    logic [WIDTH-1:0]   opnd_reg;     // multiplicand, or divisor magnitude
    logic               neg_quo_reg;
    logic               neg_rem_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               div_zero_reg;

    logic [WIDTH:0]     upper_ext;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Booth step: add/subtract the multiplicand in WIDTH+1 bits so the most
    // negative multiplicand cannot overflow, then arithmetic-shift right by one.
    always_comb begin
        upper_ext = {acc_reg[2*WIDTH], acc_reg[2*WIDTH:WIDTH+1]};
        mcand_ext = {opnd_reg[WIDTH-1], opnd_reg};
        case (acc_reg[1:0])
            2'b01:   booth_sum = upper_ext + mcand_ext;
            2'b10:   booth_sum = upper_ext - mcand_ext;
            default: booth_sum = upper_ext;
        endcase
    end

    // Dropping the old q_-1 bit realises the shift: the sum's extra sign bit
    // becomes the new top bit of the accumulator.
    assign booth_next = {booth_sum, acc_reg[WIDTH:1]};

    mult_div_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem      (acc_reg[2*WIDTH:WIDTH+1]),
        .quo      (acc_reg[WIDTH:1]),
        .divisor  (opnd_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Sign fix-up of the final division step, and operand magnitudes at start.
    // A quotient magnitude of 2^(WIDTH-1) negates to itself, giving the wrap.
    always_comb begin
        quo_fix = neg_quo_reg ? (-quo_next) : quo_next;
        rem_fix = neg_rem_reg ? (-rem_next) : rem_next;
        a_mag   = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
        b_mag   = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    end

    // Control FSM with registered busy/done/results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            neg_quo_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, FIN: begin
                    state_reg <= IDLE;
                    if (bus.start) begin
                        cnt_reg <= '0;
                        if (bus.op == OP_MULT) begin
                            state_reg <= MULT;
                            busy_reg  <= 1'b1;
                            opnd_reg  <= bus.a;
                            acc_reg   <= {{(WIDTH+1){1'b0}}, bus.b} << 1;
                        end else if (bus.b == '0) begin
                            // Divide by zero: straight to FIN, results untouched.
                            state_reg    <= FIN;
                            done_reg     <= 1'b1;
                            div_zero_reg <= 1'b1;
                        end else begin
                            state_reg   <= DIV;
                            busy_reg    <= 1'b1;
                            opnd_reg    <= b_mag;
                            acc_reg     <= {{(WIDTH+1){1'b0}}, a_mag} << 1;
                            neg_quo_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_rem_reg <= bus.a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc_reg <= booth_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        state_reg    <= FIN;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        hi_reg       <= booth_next[2*WIDTH:WIDTH+1];
                        lo_reg       <= booth_next[WIDTH:1];
                        div_zero_reg <= 1'b0;
                    end
                end
                DIV: begin
                    acc_reg <= {rem_next, quo_next, 1'b0};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        state_reg    <= FIN;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        hi_reg       <= rem_fix;
                        lo_reg       <= quo_fix;
                        div_zero_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = div_zero_reg;
endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: vector table plus hand-written sequences,
// with a scoreboard queue of expected results popped on each done pulse.
module tb_mult_div;
    import mult_div_pkg::*;

    localparam int W       = 32;
    localparam int LAT     = W + 1;   // edges from start sample to done, inclusive
    localparam int NTAB    = 15;
    localparam int NFIXED  = 11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    exp_t         scb[$];
    vec_t         tbl[NTAB];
    logic [W-1:0] mh = '0;
    logic [W-1:0] ml = '0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model built on the language's signed arithmetic in 64 bits.
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] ph, input logic [W-1:0] pl);
        exp_t        e;
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (op == OP_MULT) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (b == '0) begin
            e.hi = ph;
            e.lo = pl;
            e.dz = 1'b1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive one start pulse; returns #1 after the sampling edge.
    task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input exp_t e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        scb.push_back(e);
        mh = e.hi;
        ml = e.lo;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, counting latency and busy cycles; then compare.
    task automatic finish_op(input string name, input int lat0, input int exp_lat,
                             input int exp_busy);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat      = lat0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        if (exp_busy >= 0) check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        if (scb.size() == 0) begin
            check({name, " scoreboard_empty"}, 64'(0), 64'(1));
        end else begin
            e = scb.pop_front();
            check({name, " hi"}, 64'(bus.hi), 64'(e.hi));
            check({name, " lo"}, 64'(bus.lo), 64'(e.lo));
            check({name, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
        end
        $display("[TB] %s: hi=%h lo=%h div_zero=%0b latency=%0d busy=%0d",
                 name, bus.hi, bus.lo, bus.div_zero, lat, busy_cnt);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;
        bit           done_seen;

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        check("reset div_zero", 64'(bus.div_zero), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Vector table: fixed corner cases, then random ones through the model
        tbl[0]  = '{OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[2]  = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[3]  = '{OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
        tbl[4]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[5]  = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[6]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[7]  = '{OP_DIV,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        tbl[8]  = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};
        tbl[9]  = '{OP_DIV,  32'h0000_0003, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 1'b0};
        tbl[10] = '{OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        for (int i = NFIXED; i < NTAB; i++) begin
            rop = 1'(i % 2);
            ra  = $urandom;
            rb  = $urandom;
            if (rb == '0) rb = 32'd1;
            e = model(rop, ra, rb, '0, '0);
            tbl[i] = '{rop, ra, rb, e.hi, e.lo, e.dz};
        end

        // Consecutive entries start in the previous entry's FIN cycle
        for (int i = 0; i < NTAB; i++) begin
            e = '{tbl[i].hi, tbl[i].lo, tbl[i].dz};
            start_op(tbl[i].op, tbl[i].a, tbl[i].b, e);
            finish_op($sformatf("vec%0d op=%0d a=%h b=%h", i, tbl[i].op, tbl[i].a, tbl[i].b),
                      1, LAT, W);
        end

        // done is a single-cycle pulse and the unit falls back to idle
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("idle_not_busy", 64'(bus.busy), 64'(0));

        // Divide by zero keeps the previous hi/lo; next MULT clears div_zero
        start_op(OP_DIV, 32'h0000_0451, 32'h0000_0020, model(OP_DIV, 32'h451, 32'h20, mh, ml));
        finish_op("div 0x451/0x20", 1, LAT, W);
        start_op(OP_DIV, 32'd5, 32'd0, model(OP_DIV, 32'd5, 32'd0, mh, ml));
        finish_op("div 5/0", 1, 1, 0);
        check("div0 hi kept", 64'(bus.hi), 64'h11);
        check("div0 lo kept", 64'(bus.lo), 64'h22);
        start_op(OP_MULT, 32'd3, 32'd4, model(OP_MULT, 32'd3, 32'd4, mh, ml));
        finish_op("mult 3*4 after div0", 1, LAT, W);

        // A start pulse while busy is ignored, even with new operands
        start_op(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98,
                 model(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, mh, ml));
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'h0000_0009;
        bus.b     = 32'h0000_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_op("mult with ignored start", 11, LAT, -1);

        // Asynchronous reset in the middle of a divide
        start_op(OP_DIV, 32'h0000_03E8, 32'd7, model(OP_DIV, 32'h3E8, 32'd7, mh, ml));
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort done", 64'(bus.done), 64'(0));
        check("abort hi", 64'(bus.hi), 64'(0));
        check("abort lo", 64'(bus.lo), 64'(0));
        check("abort div_zero", 64'(bus.div_zero), 64'(0));
        void'(scb.pop_front());
        mh = '0;
        ml = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        check("abort no_done", 64'(done_seen), 64'(0));
        $display("[TB] reset abort: hi=%h lo=%h done_seen=%0b", bus.hi, bus.lo, done_seen);

        start_op(OP_DIV, 32'hFFFF_FC18, 32'd7, model(OP_DIV, 32'hFFFF_FC18, 32'd7, mh, ml));
        finish_op("div -1000/7 after reset", 1, LAT, W);
        check("div -1000/7 lo const", 64'(bus.lo), 64'(32'hFFFF_FF72));
        check("div -1000/7 hi const", 64'(bus.hi), 64'(32'hFFFF_FFFA));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
